// File: rtl/divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM state codes,
// default operand width and the saturation values used on divide-by-zero
// and MIN/-1 overflow.
package divider_pkg;

  localparam int DEFAULT_WIDTH = 18;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Largest positive two's complement value of a given width.
  function automatic logic [63:0] max_pos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Most negative two's complement value of a given width (bit pattern).
  function automatic logic [63:0] min_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

  // Saturation constants at the default width.
  localparam logic [DEFAULT_WIDTH-1:0] MAX_POS = DEFAULT_WIDTH'(max_pos(DEFAULT_WIDTH));
  localparam logic [DEFAULT_WIDTH-1:0] MIN_NEG = DEFAULT_WIDTH'(min_neg(DEFAULT_WIDTH));

endpackage

// File: rtl/divider_step.sv
// One restoring-division stage: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, report the quotient bit.
module divider_step #(
  parameter int WIDTH = 18
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Trial subtraction; the borrow out of the top bit says "divisor did not fit".
  // The partial remainder is always below the divisor magnitude, so the
  // shifted value never reaches the top bit and the borrow test is exact.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[WIDTH+1];
    rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/divider.sv
// Iterative signed divider, radix-2 restoring, one quotient bit per clock.
// Operands are converted to magnitudes on accept, the unsigned division
// runs for WIDTH cycles, and the sign correction and saturation cases are
// applied on the final iteration edge.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [WIDTH-1:0] i_Dividend,
  input  logic [WIDTH-1:0] i_Divisor,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [WIDTH-1:0] o_Quotient,
  output logic [WIDTH-1:0] o_Remainder,
  output logic             o_DivByZero,
  output logic             o_Overflow
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] SAT_MAX  = WIDTH'(max_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN  = WIDTH'(min_neg(WIDTH));

  logic [1:0]       state;
  logic [WIDTH-1:0] dvd_sh;     // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dsr_mag;    // divisor magnitude
  logic [WIDTH:0]   rem;        // partial remainder
  logic [CNT_W-1:0] cnt;
  logic             neg_q;      // operand signs differ
  logic             neg_r;      // dividend was negative
  logic             div_zero;
  logic             ovf;

  logic [WIDTH:0]   rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dsr_abs;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;
  logic             is_div_zero;
  logic             is_ovf;

  assign o_Ready = (state == ST_IDLE);
  assign o_Valid = (state == ST_DONE);

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .bit_in  (dvd_sh[WIDTH-1]),
    .divisor (dsr_mag),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // Operand magnitudes and special-case detection at the input port.
  // |MIN| wraps back to the MIN bit pattern, which is the correct unsigned magnitude.
  always_comb begin
    dvd_abs     = i_Dividend[WIDTH-1] ? -i_Dividend : i_Dividend;
    dsr_abs     = i_Divisor[WIDTH-1]  ? -i_Divisor  : i_Divisor;
    is_div_zero = (i_Divisor == '0);
    is_ovf      = (i_Dividend == SAT_MIN) && (i_Divisor == '1);
  end

  // Final result: sign correction of the last iteration, then saturation.
  // With a zero divisor every trial subtraction succeeds, so the remainder
  // accumulates the whole dividend magnitude and sign-corrects back to the
  // dividend; only the quotient needs overriding.
  // NOTE: every combinational output gets a value on every path (default
  // first, overrides after) so no latch is inferred.
  always_comb begin
    q_mag   = {dvd_sh[WIDTH-2:0], q_bit};
    q_final = neg_q ? -q_mag : q_mag;
    r_final = neg_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
    if (div_zero) begin
      q_final = neg_r ? SAT_MIN : SAT_MAX;
    end else if (ovf) begin
      q_final = SAT_MAX;
    end
  end

  // FSM, iteration datapath and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state       <= ST_IDLE;
      dvd_sh      <= '0;
      dsr_mag     <= '0;
      rem         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_zero    <= 1'b0;
      ovf         <= 1'b0;
      o_Quotient  <= '0;
      o_Remainder <= '0;
      o_DivByZero <= 1'b0;
      o_Overflow  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_Valid) begin
            neg_r    <= i_Dividend[WIDTH-1];
            neg_q    <= i_Dividend[WIDTH-1] ^ i_Divisor[WIDTH-1];
            dvd_sh   <= dvd_abs;
            dsr_mag  <= dsr_abs;
            rem      <= '0;
            cnt      <= CNT_LAST;
            div_zero <= is_div_zero;
            ovf      <= is_ovf;
            state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          rem    <= rem_next;
          dvd_sh <= {dvd_sh[WIDTH-2:0], q_bit};
          cnt    <= cnt - CNT_ONE;
          if (cnt == '0) begin
            o_Quotient  <= q_final;
            o_Remainder <= r_final;
            o_DivByZero <= div_zero;
            o_Overflow  <= ovf;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_Ready) begin
            o_DivByZero <= 1'b0;
            o_Overflow  <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/divider.md
Name: divider

Overview:
Sequential signed divider. It is the inverse-operation counterpart to the pipelined multiplier, for the operator and envelope paths that need a quotient, e.g. normalising a phase increment by a ratio.
- Iterative radix-2 restoring algorithm, one quotient bit per clock.
- Valid/ready handshakes on both the operand side and the result side.
- Truncating (C-style) semantics, with saturation on divide-by-zero and on overflow.

Parameters:
WIDTH, 18, operand/result width in bits; signed two's complement.

Ports:
i_Clock  input  1  system clock, rising-edge.
i_Reset_n  input  1  reset, asynchronous and active-low.
i_Valid  input  1  operands present.
o_Ready  output  1  divider can accept operands.
i_Dividend  input  WIDTH  signed dividend.
i_Divisor  input  WIDTH  signed divisor.
o_Valid  output  1  result present.
i_Ready  input  1  consumer accepts result.
o_Quotient  output  WIDTH  signed quotient.
o_Remainder  output  WIDTH  signed remainder.
o_DivByZero  output  1  result is from a zero divisor.
o_Overflow  output  1  result is from MIN/-1.

Behaviour:
Reset:
- While i_Reset_n=0, with asynchronous assertion and release on the next edge: state=IDLE, o_Ready=1, o_Valid=0, and o_Quotient, o_Remainder, o_DivByZero and o_Overflow are all 0.
- Reset asserted mid-operation abandons the operation immediately; no result is produced.

States: IDLE, CALC, DONE.
- o_Ready = (state==IDLE).
- o_Valid = (state==DONE).

IDLE:
- On the edge where i_Valid&&o_Ready (edge N):
  - latch the sign flags;
  - latch the magnitudes |dividend| and |divisor| as WIDTH-bit unsigned values (|-2^(WIDTH-1)| fits);
  - clear the partial remainder (WIDTH+1 bits);
  - set the bit counter to WIDTH-1;
  - go to CALC.

CALC, one edge per bit, MSB first:
- rem = {rem, next dividend bit}.
- If rem >= divisor magnitude, subtract it and set the quotient bit to 1; otherwise set it to 0.
- The counter decrements each edge.
- On the edge where counter==0 (edge N+WIDTH):
  - apply the sign correction: quotient is negated if the signs differ; remainder takes the dividend's sign;
  - register the outputs;
  - go to DONE.
- Latency is exactly WIDTH cycles from the accept edge to o_Valid=1, for every operand pair, including the special cases below.

DONE:
- Outputs are held stable while i_Ready=0.
- On the edge with i_Ready=1, go to IDLE. o_Valid falls and o_Ready rises on that edge.
- No back-to-back acceptance. Maximum throughput is one result per WIDTH+2 cycles.

Ignored inputs:
- i_Valid is ignored outside IDLE.
- Operand changes after the accept edge have no effect.

Special cases, with flags registered alongside the result:
- Divisor=0:
  - quotient = +MAX (2^(WIDTH-1)-1) if dividend >= 0, else MIN (-2^(WIDTH-1));
  - remainder = dividend;
  - o_DivByZero=1.
- Dividend=MIN and divisor=-1:
  - quotient = +MAX, remainder = 0, o_Overflow=1.
- Both flags are 0 for all other results.
- The flags are cleared when leaving DONE. Only one flag can be 1 at a time.

Arithmetic invariant (non-special cases):
- Dividend == quotient*divisor + remainder.
- |remainder| < |divisor|.
- Remainder is zero or has the dividend's sign.

Decomposition:
Package divider_pkg:
- state enum (IDLE, CALC, DONE);
- localparams for the WIDTH-dependent saturation constants (MAX_POS, MIN_NEG).

Sub-module divider_step:
- Purely combinational restoring stage.
- Inputs: partial remainder, incoming bit, divisor magnitude.
- Outputs: next remainder, quotient bit.
- Instantiated once inside divider.

Test Plan:
- Basic: 100/7, accept then hold i_Ready=1 -> o_Valid exactly 18 cycles after the accept edge, quotient 14, remainder 2, flags 0.
- Sign cases:
  - -100/7 -> quotient -14, remainder -2;
  - 100/-7 -> quotient -14, remainder 2;
  - -100/-7 -> quotient 14, remainder -2.
- Divide-by-zero:
  - 5/0 -> quotient 131071, remainder 5, o_DivByZero=1;
  - -5/0 -> quotient -131072, remainder -5, o_DivByZero=1.
- Overflow: -131072/-1 -> quotient 131071, remainder 0, o_Overflow=1. Also -131072/1 -> quotient -131072, remainder 0, flags 0.
- Handshake:
  - hold i_Ready=0 for 10 cycles in DONE -> outputs stable, o_Ready=0;
  - toggle i_Valid with new operands during CALC -> no effect on the result.
- Reset: assert i_Reset_n=0 asynchronously at CALC bit 9 -> all outputs immediately reset to their reset values. After release, 7/2 -> quotient 3, remainder 1 in 18 cycles.
